// File: rtl/boot_host.sv
// Host side of the CPU boot protocol: streams a ROM image to the bootloader over
// UART 8N1 and can check the RAM dump that the CPU echoes back.
module boot_host #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int N_WORDS      = 64,
    parameter int ADR_W        = 6,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             start,
    input  logic             verify_en,
    output logic [ADR_W-1:0] img_adr,
    input  logic [15:0]      img_data,
    output logic             tx,
    input  logic             rx,
    output logic             scan_memory,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [ADR_W:0]   err_count
);
    localparam int CNT_W   = $clog2(CLKS_PER_BIT + 1);
    localparam int TMO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TMO_W   = $clog2(TMO_CYC + 1);
    localparam int ERR_W   = ADR_W + 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TMO_CYC - 1);
    localparam logic [ADR_W-1:0] ADR_LAST  = ADR_W'(N_WORDS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = ERR_W'(N_WORDS);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] FETCH    = 3'd1;
    localparam logic [2:0] SEND_HI  = 3'd2;
    localparam logic [2:0] SEND_LO  = 3'd3;
    localparam logic [2:0] SCAN_REQ = 3'd4;
    localparam logic [2:0] RECV     = 3'd5;
    localparam logic [2:0] FINISH   = 3'd6;

    localparam logic [1:0] HUNT     = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic [2:0]       state;
    logic [CNT_W-1:0] clk_cnt;
    logic [3:0]       bit_idx;
    logic [15:0]      word_q;
    logic [7:0]       tx_byte;
    logic             verify_q;
    logic [7:0]       hi_q;
    logic             have_hi;
    logic [TMO_W-1:0] tmo_cnt;

    logic             rx_s1;
    logic             rx_s2;
    logic             rx_s3;
    logic [1:0]       rx_phase;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_byte;
    logic             rx_armed;
    logic             start_det;
    logic             stop_hit;
    logic             byte_vld;
    logic             frame_err;

    assign busy        = (state != IDLE) && (state != FINISH);
    assign done        = (state == FINISH);
    assign scan_memory = (state == SCAN_REQ);
    assign rx_armed    = (state == SCAN_REQ) || (state == RECV);
    assign start_det   = rx_armed && (rx_phase == HUNT) && rx_s3 && !rx_s2;
    assign stop_hit    = (rx_phase == RX_STOP) && (rx_cnt == BIT_LAST);
    assign byte_vld    = stop_hit && rx_s2;
    assign frame_err   = stop_hit && !rx_s2;

    // Line level is decoded straight from registered state so reset idles it at once.
    always_comb begin
        tx_byte = (state == SEND_HI) ? word_q[15:8] : word_q[7:0];
        tx      = 1'b1;
        if (state == SEND_HI || state == SEND_LO) begin
            if (bit_idx == 4'd0)
                tx = 1'b0;
            else if (bit_idx <= 4'd8)
                tx = tx_byte[3'(bit_idx - 4'd1)];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            rx_phase <= HUNT;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_byte  <= '0;
        end else if (ce) begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
            if (!rx_armed) begin
                rx_phase <= HUNT;
            end else begin
                case (rx_phase)
                    HUNT: if (start_det) begin
                        rx_phase <= RX_START;
                        rx_cnt   <= '0;
                    end
                    RX_START: if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_phase <= rx_s2 ? HUNT : RX_DATA;
                    end else rx_cnt <= rx_cnt + 1'b1;
                    RX_DATA: if (rx_cnt == BIT_LAST) begin
                        rx_cnt  <= '0;
                        rx_byte <= {rx_s2, rx_byte[7:1]};
                        rx_bit  <= rx_bit + 1'b1;
                        if (rx_bit == 3'd7) rx_phase <= RX_STOP;
                    end else rx_cnt <= rx_cnt + 1'b1;
                    default: if (rx_cnt == BIT_LAST) rx_phase <= HUNT;
                             else rx_cnt <= rx_cnt + 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            img_adr   <= '0;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            word_q    <= '0;
            verify_q  <= 1'b0;
            hi_q      <= '0;
            have_hi   <= 1'b0;
            tmo_cnt   <= '0;
            error     <= 1'b0;
            err_count <= '0;
        end else if (ce) begin
            case (state)
                IDLE: if (start) begin
                    error     <= 1'b0;
                    err_count <= '0;
                    img_adr   <= '0;
                    clk_cnt   <= '0;
                    bit_idx   <= '0;
                    have_hi   <= 1'b0;
                    verify_q  <= verify_en;
                    state     <= FETCH;
                end
                FETCH: state <= SEND_HI;
                SEND_HI, SEND_LO: begin
                    // ROM output has settled by the first start-bit cycle.
                    if (state == SEND_HI && bit_idx == 4'd0 && clk_cnt == '0)
                        word_q <= img_data;
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        if (bit_idx == 4'd9) begin
                            bit_idx <= '0;
                            if (state == SEND_HI) begin
                                state <= SEND_LO;
                            end else if (img_adr == ADR_LAST) begin
                                img_adr <= '0;
                                state   <= verify_q ? SCAN_REQ : FINISH;
                            end else begin
                                img_adr <= img_adr + 1'b1;
                                state   <= FETCH;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                SCAN_REQ, RECV: begin
                    if (state == SCAN_REQ) begin
                        tmo_cnt <= '0;
                        if (clk_cnt == BIT_LAST) begin
                            clk_cnt <= '0;
                            state   <= RECV;
                        end else clk_cnt <= clk_cnt + 1'b1;
                    end else if (start_det) tmo_cnt <= '0;
                    else tmo_cnt <= tmo_cnt + 1'b1;

                    // Later assignments to state take precedence over the scan timer.
                    if (frame_err) begin
                        error <= 1'b1;
                        state <= FINISH;
                    end else if (byte_vld) begin
                        if (!have_hi) begin
                            hi_q    <= rx_byte;
                            have_hi <= 1'b1;
                        end else begin
                            have_hi <= 1'b0;
                            if ({hi_q, rx_byte} != img_data) begin
                                error <= 1'b1;
                                if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
                            end
                            if (img_adr == ADR_LAST) state <= FINISH;
                            else img_adr <= img_adr + 1'b1;
                        end
                    end else if (state == RECV && tmo_cnt == TMO_LAST) begin
                        error <= 1'b1;
                        state <= FINISH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
